stack_mon: RTL
==============

Name: stack_mon

Overview:
- Hardware stack monitor; sits downstream of the system configuration device and consumes the same stack layout (stack_org, stack_size).
- Watches the CPU stack pointer every cycle, tracks the lowest address reached (high-water mark), and raises trap pulses on limit violations.
- CPU-visible as one IO device with four 32-bit registers on the standard stb/we/ack IO strobe interface.

Parameters:
- stack_org, 'h30000, top of stack (stack grows down); HWM reset/re-arm value
- stack_size, 'h4000, stack size in bytes; LIMIT reset = stack_org - stack_size
- hot_margin, 'h400, bytes above LIMIT for the early-warning limit; HOTLIMIT reset = LIMIT reset + hot_margin
- aw, 24, stack pointer/address width in bits

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- stb  in  1  IO device select strobe, one cycle per access
- we  in  1  1 = write, 0 = read
- addr  in  2  register select: 0 CTRL, 1 LIMIT, 2 HOTLIMIT, 3 HWM
- data_in  in  32  write data
- data_out  out  32  read data, registered
- ack  out  1  access acknowledge
- sp  in  aw  CPU stack pointer
- sp_vld  in  1  sp is valid this cycle
- trap_lim  out  1  one-cycle pulse on LIMIT violation
- trap_hot  out  1  one-cycle pulse on HOTLIMIT violation

Behaviour:
- Reset values: CTRL = 0 (disabled, flags clear); LIMIT = stack_org - stack_size; HOTLIMIT = LIMIT + hot_margin; HWM = stack_org; data_out = 0; ack = 0; trap_lim = trap_hot = 0.
- CTRL fields:
  - bit0 en (R/W).
  - bit1 lim_hit, sticky; write 1 clears, write 0 has no effect.
  - bit2 hot_hit, sticky; write 1 clears, write 0 has no effect.
  - bits 31:3 read 0.
- LIMIT, HOTLIMIT: R/W. Write data_in[aw-1:0]; read zero-extended to 32 bits.
- HWM: read returns the minimum sp seen. Any write re-arms HWM to stack_org; write data is ignored.
- IO timing:
  - Register writes take effect at the clk edge where stb & we.
  - Reads: data_out is loaded at the edge where stb & ~we; it holds until the next read. Writes leave data_out unchanged.
  - ack is registered: high exactly the cycle after stb, for reads and writes.
  - Back-to-back strobes are legal.
- Monitoring (only when en = 1 and sp_vld = 1, unsigned compare):
  - HWM update: if sp < HWM, then HWM <= sp.
  - Limit check: lim_cond = sp < LIMIT; hot_cond = sp < HOTLIMIT.
  - lim_cond & ~lim_hit sets lim_hit and pulses trap_lim for one cycle, in the cycle after the sample. Further samples do not re-pulse until lim_hit is cleared.
  - trap_hot / hot_hit: same rule using hot_cond.
  - en = 0 or sp_vld = 0: no HWM update, no flag changes, no pulses.
- Simultaneous events:
  - A write to LIMIT/HOTLIMIT in the same cycle as a check: the check uses the old value.
  - A W1C clear in the same cycle a new violation sets the flag: set wins, and the trap pulses.
  - An HWM write in the same cycle as an update from sp: HWM <= min(stack_org, sp).
  - A CTRL write that sets en: monitoring starts from the next cycle.
- sp = 0 with LIMIT = 0: no violation (strict less-than).
- Reset mid-operation returns all state to reset values asynchronously; any pulse in flight is dropped.

Decomposition:
- Shared package (sysconf/IO package):
  - register index constants CTRL_IX = 0, LIMIT_IX = 1, HOTLIMIT_IX = 2, HWM_IX = 3;
  - CTRL bit positions EN_BIT = 0, LIM_HIT_BIT = 1, HOT_HIT_BIT = 2;
  - default stack_org/stack_size values, shared with sysconf so the two never diverge.
- One natural sub-module: stack_mon_chk. It holds one limit register, its sticky flag and its pulse generator, and is instantiated twice (LIMIT and HOTLIMIT). The HWM and IO logic live in the top.

Test Plan:
- Reset, then read each register (addr 0..3): CTRL = 0, LIMIT = 'h2C000, HOTLIMIT = 'h2C400, HWM = 'h30000; ack high exactly one cycle after each stb.
- en = 1, sp steps 'h2FF00 -> 'h2E000 -> 'h2F000 -> 'h2D800: HWM reads 'h2D800; no traps.
- en = 1, sp = 'h2C3F0: trap_hot one-cycle pulse, CTRL = 'h5. Hold sp for 10 cycles: no further pulses. Then sp = 'h2BFF0: trap_lim pulses, CTRL = 'h7.
- With lim_hit set and sp still 'h2BFF0: write CTRL = 'h3 (W1C lim_hit, same cycle as a violation) -> set wins, trap_lim pulses again, lim_hit remains 1.
- en = 0, sp = 'h10000 for 5 cycles: no pulses, HWM unchanged; write HWM (any data) -> HWM reads 'h30000.
- Write LIMIT = 'h2E000 in the same cycle as sp = 'h2DFF0: no trap that cycle; trap_lim pulses on the next valid sample. Assert rst_n = 0 mid-pulse: trap_lim drops immediately and all registers read reset values.

Source files
------------

// File: rtl/stack_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_mon_pkg
// Description : Shared IO/sysconf definitions for the stack monitor: register
//               indices, CTRL bit positions and the default stack layout
//               (kept here so sysconf and stack_mon can never disagree).
// Revision    : 1.0 - initial release
// ============================================================================
package stack_mon_pkg;

  // Register select values on addr
  localparam logic [1:0] CTRL_IX     = 2'd0;
  localparam logic [1:0] LIMIT_IX    = 2'd1;
  localparam logic [1:0] HOTLIMIT_IX = 2'd2;
  localparam logic [1:0] HWM_IX      = 2'd3;

  // CTRL bit positions
  localparam int EN_BIT      = 0;
  localparam int LIM_HIT_BIT = 1;
  localparam int HOT_HIT_BIT = 2;

  // Default stack layout (stack grows down from DEF_STACK_ORG)
  localparam int DEF_STACK_ORG  = 'h30000;
  localparam int DEF_STACK_SIZE = 'h4000;
  localparam int DEF_HOT_MARGIN = 'h400;

endpackage : stack_mon_pkg
`default_nettype wire

// File: rtl/stack_mon_chk.sv
`default_nettype none
// ============================================================================
// Module      : stack_mon_chk
// Description : One stack limit checker: a writable limit register, its
//               sticky hit flag (write-1-to-clear) and a one-cycle trap pulse.
// Ports       : clk, rst_n      - clock, async active-low reset
//               check_en        - sp is valid and monitoring is enabled
//               sp              - stack pointer sample
//               wr / wr_data    - load a new limit (check uses the old one)
//               clr             - clear sticky flag (a new hit wins)
//               limit, hit      - current limit and sticky flag
//               trap            - one-cycle pulse when the flag gets set
// Revision    : 1.0 - initial release
// ============================================================================
module stack_mon_chk #(
  parameter int AW          = 24,
  parameter int RESET_LIMIT = 'h2C000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          check_en,
  input  logic [AW-1:0] sp,
  input  logic          wr,
  input  logic [AW-1:0] wr_data,
  input  logic          clr,
  output logic [AW-1:0] limit,
  output logic          hit,
  output logic          trap
);

  logic cond;
  assign cond = check_en && (sp < limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit <= AW'(RESET_LIMIT);
      hit   <= 1'b0;
      trap  <= 1'b0;
    end else begin
      if (wr) begin
        limit <= wr_data;
      end
      // A violation in the same cycle as a clear re-sets the flag and
      // re-pulses, so a hit is never lost behind a software clear.
      hit  <= cond | (hit & ~clr);
      trap <= cond & (~hit | clr);
    end
  end

endmodule : stack_mon_chk
`default_nettype wire

// File: rtl/stack_mon.sv
`default_nettype none
// ============================================================================
// Module      : stack_mon
// Description : Hardware stack monitor. Tracks the lowest stack pointer seen
//               (HWM) and pulses traps on LIMIT / HOTLIMIT violations.
//               Four 32-bit registers on the stb/we/ack IO interface:
//               0 CTRL, 1 LIMIT, 2 HOTLIMIT, 3 HWM.
// Ports       : clk, rst_n           - clock, async active-low reset
//               stb, we, addr        - IO strobe, write enable, reg select
//               data_in / data_out   - write data / registered read data
//               ack                  - acknowledge, cycle after stb
//               sp, sp_vld           - CPU stack pointer and its valid
//               trap_lim, trap_hot   - one-cycle violation pulses
// Revision    : 1.0 - initial release
// ============================================================================
module stack_mon
  import stack_mon_pkg::*;
#(
  parameter int STACK_ORG  = DEF_STACK_ORG,
  parameter int STACK_SIZE = DEF_STACK_SIZE,
  parameter int HOT_MARGIN = DEF_HOT_MARGIN,
  parameter int AW         = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stb,
  input  logic          we,
  input  logic [1:0]    addr,
  input  logic [31:0]   data_in,
  output logic [31:0]   data_out,
  output logic          ack,
  input  logic [AW-1:0] sp,
  input  logic          sp_vld,
  output logic          trap_lim,
  output logic          trap_hot
);

  localparam int            LIMIT_RST = STACK_ORG - STACK_SIZE;
  localparam int            HOT_RST   = LIMIT_RST + HOT_MARGIN;
  localparam logic [AW-1:0] ORG       = AW'(STACK_ORG);

  logic          en;
  logic [AW-1:0] hwm;
  logic [AW-1:0] limit;
  logic [AW-1:0] hot_limit;
  logic          lim_hit;
  logic          hot_hit;
  logic          mon;
  logic          wr;
  logic          rd;
  logic          wr_ctrl;
  logic [31:0]   ctrl_val;

  // Upper data_in bits are only meaningful for CTRL low bits / AW-wide regs
  logic unused_data;
  assign unused_data = &{1'b0, data_in};

  assign mon     = en & sp_vld;
  assign wr      = stb & we;
  assign rd      = stb & ~we;
  assign wr_ctrl = wr && (addr == CTRL_IX);

  always_comb begin
    ctrl_val              = '0;
    ctrl_val[EN_BIT]      = en;
    ctrl_val[LIM_HIT_BIT] = lim_hit;
    ctrl_val[HOT_HIT_BIT] = hot_hit;
  end

  stack_mon_chk #(.AW(AW), .RESET_LIMIT(LIMIT_RST)) u_chk_lim (
    .clk      (clk),
    .rst_n    (rst_n),
    .check_en (mon),
    .sp       (sp),
    .wr       (wr && (addr == LIMIT_IX)),
    .wr_data  (data_in[AW-1:0]),
    .clr      (wr_ctrl && data_in[LIM_HIT_BIT]),
    .limit    (limit),
    .hit      (lim_hit),
    .trap     (trap_lim)
  );

  stack_mon_chk #(.AW(AW), .RESET_LIMIT(HOT_RST)) u_chk_hot (
    .clk      (clk),
    .rst_n    (rst_n),
    .check_en (mon),
    .sp       (sp),
    .wr       (wr && (addr == HOTLIMIT_IX)),
    .wr_data  (data_in[AW-1:0]),
    .clr      (wr_ctrl && data_in[HOT_HIT_BIT]),
    .limit    (hot_limit),
    .hit      (hot_hit),
    .trap     (trap_hot)
  );

  // Enable and high-water mark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= 1'b0;
      hwm <= ORG;
    end else begin
      if (wr_ctrl) begin
        en <= data_in[EN_BIT];
      end
      if (wr && (addr == HWM_IX)) begin
        // Re-arm, but do not lose a lower sample taken in the same cycle
        hwm <= (mon && (sp < ORG)) ? sp : ORG;
      end else if (mon && (sp < hwm)) begin
        hwm <= sp;
      end
    end
  end

  // IO read path and acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      ack      <= 1'b0;
    end else begin
      ack <= stb;
      if (rd) begin
        case (addr)
          CTRL_IX:     data_out <= ctrl_val;
          LIMIT_IX:    data_out <= 32'(limit);
          HOTLIMIT_IX: data_out <= 32'(hot_limit);
          default:     data_out <= 32'(hwm);
        endcase
      end
    end
  end

endmodule : stack_mon
`default_nettype wire
